// File: rtl/park_pkg.sv
// Shared constants for the parking view input front end.
// The optional button auto-repeat is enabled by defining AUTO_REPEAT_EN.
package park_pkg;

  // Default geometry and timing
  localparam int unsigned N_KEY_DEF      = 16;
  localparam int unsigned N_BT_DEF       = 5;
  localparam int unsigned SAMPLE_DIV_DEF = 1_000_000;
  localparam int unsigned STABLE_N_DEF   = 3;
  localparam int unsigned REPEAT_TK_DEF  = 50;

  // Push-button indices into raw_bt / bt_pulse
  localparam int unsigned BT_UP    = 0;
  localparam int unsigned BT_LEFT  = 1;
  localparam int unsigned BT_RIGHT = 2;
  localparam int unsigned BT_MID   = 3;
  localparam int unsigned BT_DOWN  = 4;

endpackage

// File: rtl/park_debounce_cell.sv
// One input line: 2-flop synchroniser, tick-sampled history, debounced level and rise pulse.
// A line seen held since reset must first be observed released before it can pulse.
module park_debounce_cell
  import park_pkg::*;
#(
  parameter int unsigned STABLE_N = STABLE_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic                sync1_q, sync2_q;
  logic [STABLE_N-1:0] hist_q, hist_d;
  logic [STABLE_N-1:0] vld_q, vld_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                armed_q, armed_d;

  // History shift, level hysteresis and arming on genuine all-zero history
  always_comb begin
    hist_d  = hist_q;
    vld_d   = vld_q;
    level_d = level_q;
    armed_d = armed_q;
    if (tick) begin
      hist_d = {hist_q[STABLE_N-2:0], sync2_q};
      vld_d  = {vld_q[STABLE_N-2:0], 1'b1};
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (hist_d == '0) begin
        level_d = 1'b0;
      end
      if ((&vld_d) && (hist_d == '0)) begin
        armed_d = 1'b1;
      end
    end
    rise_d = level_d & ~level_q & armed_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      vld_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      vld_q   <= vld_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      armed_q <= armed_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/park_input_conditioner.sv
// Keypad/button conditioner: prescaler, per-line debounce cells, one-hot key arbitration,
// multi-key flag. Define AUTO_REPEAT_EN to make held buttons re-pulse every REPEAT_TK ticks.
module park_input_conditioner
  import park_pkg::*;
#(
  parameter int unsigned N_KEY      = N_KEY_DEF,
  parameter int unsigned N_BT       = N_BT_DEF,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int unsigned STABLE_N   = STABLE_N_DEF
`ifdef AUTO_REPEAT_EN
  , parameter int unsigned REPEAT_TK = REPEAT_TK_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_KEY-1:0] raw_key,
  input  logic [N_BT-1:0]  raw_bt,
  output logic [N_KEY-1:0] key_pulse,
  output logic [N_BT-1:0]  bt_pulse,
  output logic [N_KEY-1:0] key_level,
  output logic             key_multi
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [N_KEY-1:0] key_lvl, key_rise;
  logic [N_BT-1:0]  bt_lvl, bt_rise;
  logic [N_KEY-1:0] key_pulse_q, key_pulse_d;
  logic [N_BT-1:0]  bt_pulse_q, bt_pulse_d;
  logic             key_multi_q, key_multi_d;
  logic             key_onehot;

  // Sample prescaler: tick on the wrap of 0..SAMPLE_DIV-1
  assign tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // One debounce cell per keypad line
  for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
    park_debounce_cell #(.STABLE_N(STABLE_N)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (raw_key[gi]),
      .level (key_lvl[gi]),
      .rise  (key_rise[gi])
    );
  end

  // One debounce cell per push button
  for (genvar gb = 0; gb < N_BT; gb++) begin : g_bt
    park_debounce_cell #(.STABLE_N(STABLE_N)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (raw_bt[gb]),
      .level (bt_lvl[gb]),
      .rise  (bt_rise[gb])
    );
  end

  // Key arbitration: a press only counts when it is the sole key held
  always_comb begin
    key_onehot  = (key_rise != '0) && ((key_rise & (key_rise - N_KEY'(1))) == '0);
    key_pulse_d = '0;
    if (key_onehot && ((key_lvl & ~key_rise) == '0)) begin
      key_pulse_d = key_rise;
    end
    key_multi_d = ($countones(key_lvl) > 1);
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_TK > 1) ? $clog2(REPEAT_TK) : 1;

  logic                       tick_d_q;
  logic [N_BT-1:0]            rep_act_q, rep_act_d;
  logic [N_BT-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [N_BT-1:0]            rep_fire;

  // Repeat counters step one cycle after each tick so repeats align with the rise cycle
  always_comb begin
    rep_act_d = rep_act_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = '0;
    for (int i = 0; i < int'(N_BT); i++) begin
      if (!bt_lvl[i]) begin
        rep_act_d[i] = 1'b0;
        rep_cnt_d[i] = '0;
      end else if (bt_rise[i]) begin
        rep_act_d[i] = 1'b1;
        rep_cnt_d[i] = '0;
      end else if (rep_act_q[i] && tick_d_q) begin
        if (rep_cnt_q[i] == REP_W'(REPEAT_TK - 1)) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = '0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end
    end
    bt_pulse_d = bt_rise | rep_fire;
  end

  // Repeat state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d_q  <= 1'b0;
      rep_act_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      tick_d_q  <= tick;
      rep_act_q <= rep_act_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  // Single pulse per press; a rise always coincides with a high level
  always_comb begin
    bt_pulse_d = bt_rise & bt_lvl;
  end
`endif

  // Prescaler and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      key_pulse_q <= '0;
      bt_pulse_q  <= '0;
      key_multi_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      key_pulse_q <= key_pulse_d;
      bt_pulse_q  <= bt_pulse_d;
      key_multi_q <= key_multi_d;
    end
  end

  assign key_pulse = key_pulse_q;
  assign bt_pulse  = bt_pulse_q;
  assign key_level = key_lvl;
  assign key_multi = key_multi_q;

endmodule

// File: tb/tb_park_input_conditioner.sv
// Directed bench for park_input_conditioner with SAMPLE_DIV=4, STABLE_N=3, REPEAT_TK=5.
module tb_park_input_conditioner;

  logic        clk;
  logic        rst;
  logic [15:0] raw_key;
  logic [4:0]  raw_bt;
  logic [15:0] key_pulse;
  logic [4:0]  bt_pulse;
  logic [15:0] key_level;
  logic        key_multi;

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping filled by run()
  int          cyc;
  int          kp_n, bp_n, bp_t1, bp_t2;
  logic [15:0] kp_val;
  logic [4:0]  bp_val;

  // Shape monitor: width and one-hot violations
  int          wide_n   = 0;
  int          nonhot_n = 0;
  logic [15:0] prev_kp  = '0;
  logic [4:0]  prev_bp  = '0;

  park_input_conditioner #(
    .N_KEY      (16),
    .N_BT       (5),
    .SAMPLE_DIV (4),
    .STABLE_N   (3)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_TK (5)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_key   (raw_key),
    .raw_bt    (raw_bt),
    .key_pulse (key_pulse),
    .bt_pulse  (bt_pulse),
    .key_level (key_level),
    .key_multi (key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (((key_pulse & prev_kp) != '0) || ((bt_pulse & prev_bp) != '0)) wide_n++;
    if ((key_pulse != '0) && ((key_pulse & (key_pulse - 16'd1)) != '0)) nonhot_n++;
    prev_kp = key_pulse;
    prev_bp = bt_pulse;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; kp_n = 0; bp_n = 0; bp_t1 = 0; bp_t2 = 0;
    kp_val = '0; bp_val = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (key_pulse != '0) begin kp_n++; kp_val = key_pulse; end
      if (bt_pulse != '0) begin
        bp_n++; bp_val = bt_pulse;
        if (bp_n == 1) bp_t1 = cyc;
        if (bp_n == 2) bp_t2 = cyc;
      end
    end
  endtask

  initial begin
    raw_key = '0;
    raw_bt  = '0;
    rst     = 1'b1;
    clr();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_pulse", 32'(key_pulse), 32'h0);
    chk("rst_bt_pulse",  32'(bt_pulse),  32'h0);
    chk("rst_key_level", 32'(key_level), 32'h0);
    chk("rst_key_multi", 32'(key_multi), 32'h0);
    rst = 1'b1;
    run(24);
    chk("idle_no_pulse", 32'(kp_n + bp_n), 32'd0);

    // 1: confirm button press and release
    clr();
    raw_bt[3] = 1'b1;
    run(30);
    chk("t1_bt_count",   32'(bp_n),   32'd1);
    chk("t1_bt_value",   32'(bp_val), 32'h08);
    chk("t1_latency_ok", 32'((bp_t1 >= 10) && (bp_t1 <= 15)), 32'd1);
    raw_bt[3] = 1'b0;
    run(24);
    chk("t1_release_nopulse", 32'(bp_n), 32'd1);

    // 2: bouncing key 2, then stable
    clr();
    for (int i = 0; i < 10; i++) begin
      raw_key[2] = ~raw_key[2];
      run(3);
    end
    chk("t2_bounce_nopulse", 32'(kp_n),      32'd0);
    chk("t2_bounce_level",   32'(key_level), 32'h0);
    raw_key[2] = 1'b1;
    run(30);
    chk("t2_stable_count", 32'(kp_n),      32'd1);
    chk("t2_stable_value", 32'(kp_val),    32'h0004);
    chk("t2_stable_level", 32'(key_level), 32'h0004);
    raw_key[2] = 1'b0;
    run(24);
    chk("t2_release_level", 32'(key_level), 32'h0);

    // 3: key 10 held, then key 5 added
    clr();
    raw_key[10] = 1'b1;
    run(24);
    chk("t3_k10_count", 32'(kp_n),   32'd1);
    chk("t3_k10_value", 32'(kp_val), 32'h0400);
    clr();
    raw_key[5] = 1'b1;
    run(24);
    chk("t3_k5_dropped", 32'(kp_n),      32'd0);
    chk("t3_level",      32'(key_level), 32'h0420);
    chk("t3_multi",      32'(key_multi), 32'd1);
    raw_key[10] = 1'b0;
    raw_key[5]  = 1'b0;
    run(24);
    chk("t3_release_multi", 32'(key_multi), 32'd0);

    // 4: keys 0 and 9 rise together
    clr();
    raw_key[0] = 1'b1;
    raw_key[9] = 1'b1;
    run(26);
    chk("t4_no_pulse", 32'(kp_n),      32'd0);
    chk("t4_multi",    32'(key_multi), 32'd1);
    chk("t4_level",    32'(key_level), 32'h0201);
    raw_key = '0;
    run(24);

    // 5: reset while key 0 is held
    clr();
    raw_key[0] = 1'b1;
    run(24);
    chk("t5_first_count", 32'(kp_n),      32'd1);
    chk("t5_first_level", 32'(key_level), 32'h0001);
    rst = 1'b0;
    #1;
    chk("t5_rst_level", 32'(key_level), 32'h0);
    chk("t5_rst_pulse", 32'(key_pulse), 32'h0);
    chk("t5_rst_multi", 32'(key_multi), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    clr();
    run(30);
    chk("t5_held_nopulse", 32'(kp_n),      32'd0);
    chk("t5_held_level",   32'(key_level), 32'h0001);
    raw_key[0] = 1'b0;
    run(24);
    raw_key[0] = 1'b1;
    run(24);
    chk("t5_repress_count", 32'(kp_n),   32'd1);
    chk("t5_repress_value", 32'(kp_val), 32'h0001);
    raw_key[0] = 1'b0;
    run(24);

    // 6: button 0 held for 200 cycles
    clr();
    raw_bt[0] = 1'b1;
    run(200);
    chk("t6_value", 32'(bp_val), 32'h01);
`ifdef AUTO_REPEAT_EN
    chk("t6_repeat_count", 32'(bp_n),          32'd10);
    chk("t6_repeat_gap",   32'(bp_t2 - bp_t1), 32'd20);
`else
    chk("t6_single_count", 32'(bp_n), 32'd1);
`endif
    clr();
    raw_bt[0] = 1'b0;
    run(40);
    chk("t6_after_release", 32'(bp_n), 32'd0);

    chk("shape_width",  32'(wide_n),   32'd0);
    chk("shape_onehot", 32'(nonhot_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
